// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default width,
// FSM state encoding and the iteration counter sizing helper.
package mul_seq_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, magnitude
// multiply with a final conditional negate for signed operands.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or
  // DONE); done pulses for exactly one cycle and the product stays valid
  // on prod_hi/prod_lo until the next done or reset.

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_sh;
  logic [WIDTH-1:0]     mplier_sh;
  logic [2*WIDTH-1:0]   raw;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    count_d  = count_q;
    prod_d   = prod_q;

    // One iteration: conditional add into the upper half, then shift
    // {carry, acc, mplier} right so product bits fill mplier from the top.
    addend    = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
    sum       = {1'b0, acc_q} + {1'b0, addend};
    acc_sh    = sum[WIDTH:1];
    mplier_sh = {sum[0], mplier_q[WIDTH-1:1]};
    raw       = {acc_sh, mplier_sh};
    result    = neg_q ? (~raw + 1'b1) : raw;

    // -0x8000 wraps to 0x8000, which is the correct unsigned magnitude.
    a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
        end
      end
      RUN: begin
        acc_d    = acc_sh;
        mplier_d = mplier_sh;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
          prod_d  = result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign prod_lo   = prod_q[WIDTH-1:0];
  assign prod_hi   = prod_q[2*WIDTH-1:WIDTH];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: randomized and directed operands, an
// arithmetic reference model feeding an expected queue, and a done monitor.
module tb_mul_seq;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] prod_lo;
  logic [W-1:0] prod_hi;
  logic [1:0]   dbg_state;

  mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .prod_lo   (prod_lo),
    .prod_hi   (prod_hi),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             start_q[$];
  logic [2*W-1:0] last_prod = '0;
  int             tests = 0;
  int             fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer multiplication of the operands as read.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms);
    longint pa, pb, p;
    if (ms) begin
      pa = longint'($signed(ma));
      pb = longint'($signed(mb));
    end else begin
      pa = longint'({1'b0, ma});
      pb = longint'({1'b0, mb});
    end
    p = pa * pb;
    return p[2*W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1) begin
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL issue_timeout: busy still 1 after %0d cycles, required 0", n);
        return;
      end
      @(negedge clk);
    end
    start     = 1'b1;
    a         = ia;
    b         = ib;
    signed_op = is;
    exp_q.push_back(model(ia, ib, is));
    start_q.push_back(cyc + 1);
    @(negedge clk);
    start     = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    signed_op = 1'($urandom);
  endtask

  // Drive start with junk operands while the multiplier is busy.
  task automatic poke_while_busy();
    repeat (2) @(negedge clk);
    check("busy_in_run", {31'b0, busy}, 32'd1);
    start     = 1'b1;
    a         = 16'h0002;
    b         = 16'h0002;
    signed_op = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (busy === 1'b1 && done === 1'b1) check("busy_and_done", 32'd1, 32'd0);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          logic [2*W-1:0] e;
          int s;
          e = exp_q.pop_front();
          s = start_q.pop_front();
          check("product", {prod_hi, prod_lo}, e);
          check("latency", 32'(cyc - s), 32'(W));
          last_prod = e;
        end
      end else begin
        check("prod_hold", {prod_hi, prod_lo}, last_prod);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;

    idle(3);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_prod", {prod_hi, prod_lo}, 32'd0);
    check("reset_state", {30'b0, dbg_state}, 32'd0);
    #2 reset = 1'b0;

    // 3*5 with start ignored mid-run, then 0x10*0x10 accepted in DONE.
    issue(16'h0003, 16'h0005, 1'b0);
    poke_while_busy();
    issue(16'h0010, 16'h0010, 1'b0);
    idle(20);

    issue(16'hFFFF, 16'hFFFF, 1'b0);
    issue(16'hFFFD, 16'h0007, 1'b1);
    issue(16'h8000, 16'h8000, 1'b1);
    issue(16'h8000, 16'h7FFF, 1'b1);
    issue(16'h0000, 16'hFFFF, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1);

    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end
    idle(20);

    // Asynchronous reset in the middle of a run.
    issue(16'h1234, 16'h5678, 1'b0);
    idle(7);
    #2 reset = 1'b1;
    #1;
    check("midrun_busy", {31'b0, busy}, 32'd0);
    check("midrun_done", {31'b0, done}, 32'd0);
    check("midrun_prod", {prod_hi, prod_lo}, 32'd0);
    check("midrun_state", {30'b0, dbg_state}, 32'd0);
    exp_q.delete();
    start_q.delete();
    last_prod = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    idle(25);

    issue(16'h0123, 16'h0456, 1'b0);
    issue(16'hFF00, 16'h0100, 1'b1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
